// File: rtl/d_ff_pkg.sv
// d_ff_pkg: shared constants and helpers for the d_ff_pipe_sr register pipeline.
//   WidthMin/WidthMax : legal range of the data width parameter
//   DepthMin/DepthMax : legal range of the stage count parameter
//   occ_width()       : bit width of the occupancy count for a given depth
package d_ff_pkg;

  localparam int unsigned WidthMin = 1;
  localparam int unsigned WidthMax = 64;
  localparam int unsigned DepthMin = 1;
  localparam int unsigned DepthMax = 16;

  // Occupancy spans 0..depth inclusive, so depth+1 distinct values.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_pipe_sr_if.sv
// d_ff_pipe_sr_if: bundles the control/data inputs and the observed outputs of d_ff_pipe_sr.
//   en, sclr, sset : advance enable, synchronous clear, synchronous set
//   d, vin         : data and valid qualifier into stage 0
//   q, qn          : last-stage data and its bitwise complement
//   vout, occ      : last-stage valid and count of valid stages
// master drives the inputs (integrator/bench); slave is the pipeline itself.
interface d_ff_pipe_sr_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  import d_ff_pkg::*;

  localparam int unsigned OccW = occ_width(DEPTH);

  logic             en;
  logic             sclr;
  logic             sset;
  logic [WIDTH-1:0] d;
  logic             vin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             vout;
  logic [OccW-1:0]  occ;

  modport master (
    output en, sclr, sset, d, vin,
    input  q, qn, vout, occ
  );

  modport slave (
    input  en, sclr, sset, d, vin,
    output q, qn, vout, occ
  );

endinterface

// File: rtl/d_ff_stage.sv
// d_ff_stage: one pipeline stage holding WIDTH data bits plus a valid bit.
//   i_clk, i_rstn   : clock, asynchronous active-low reset
//   i_en            : load i_d/i_vin when no clear or set is pending
//   i_sclr, i_sset  : synchronous clear / set, clear has priority
//   i_d, i_vin      : incoming data and valid
//   o_q, o_vout     : stored data and valid
module d_ff_stage #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_sclr,
  input  logic             i_sset,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_vin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_vout
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Set and clear both empty the stage; only the data pattern differs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_data  <= RST_VAL;
      r_valid <= 1'b0;
    end else if (i_sclr) begin
      r_data  <= RST_VAL;
      r_valid <= 1'b0;
    end else if (i_sset) begin
      r_data  <= SET_VAL;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_data  <= i_d;
      r_valid <= i_vin;
    end
  end

  assign o_q    = r_data;
  assign o_vout = r_valid;

endmodule

// File: rtl/d_ff_pipe_sr.sv
// d_ff_pipe_sr: DEPTH-stage shift pipeline of WIDTH-bit data with per-stage valid,
// synchronous set/clear and an advance enable.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : slave side of d_ff_pipe_sr_if
//               in : en, sclr, sset, d, vin
//               out: q/qn (last stage data and complement), vout (last stage valid),
//                    occ (number of valid stages)
// All outputs are decoded from stage registers only.
module d_ff_pipe_sr
  import d_ff_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input logic            clk,
  input logic            rstn,
  d_ff_pipe_sr_if.slave  bus
);

  localparam int unsigned OccW = occ_width(DEPTH);

  logic [WIDTH-1:0] w_data [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [OccW-1:0]  w_occ;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_d_in;
    logic             w_v_in;

    if (g == 0) begin : g_head
      assign w_d_in = bus.d;
      assign w_v_in = bus.vin;
    end else begin : g_body
      assign w_d_in = w_data[g-1];
      assign w_v_in = w_valid[g-1];
    end

    d_ff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL),
      .SET_VAL (SET_VAL)
    ) u_stage (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_en   (bus.en),
      .i_sclr (bus.sclr),
      .i_sset (bus.sset),
      .i_d    (w_d_in),
      .i_vin  (w_v_in),
      .o_q    (w_data[g]),
      .o_vout (w_valid[g])
    );
  end

  // Popcount of the valid vector; OccW is sized so DEPTH never wraps.
  always_comb begin
    w_occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OccW'(w_valid[i]);
    end
  end

  assign bus.q    = w_data[DEPTH-1];
  assign bus.qn   = ~w_data[DEPTH-1];
  assign bus.vout = w_valid[DEPTH-1];
  assign bus.occ  = w_occ;

endmodule

// File: tb/tb_d_ff_pipe_sr.sv
// tb_d_ff_pipe_sr: self-checking bench for d_ff_pipe_sr in an 8x4 and a 1x1 configuration.
module tb_d_ff_pipe_sr;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  d_ff_pipe_sr_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
  d_ff_pipe_sr_if #(.WIDTH(1), .DEPTH(1)) bus_b ();

  d_ff_pipe_sr #(
    .WIDTH   (8),
    .DEPTH   (4),
    .RST_VAL (8'h00),
    .SET_VAL (8'hFF)
  ) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a.slave)
  );

  d_ff_pipe_sr #(
    .WIDTH   (1),
    .DEPTH   (1),
    .RST_VAL (1'b0),
    .SET_VAL (1'b1)
  ) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference contents of the 8x4 pipeline, {valid, data}, index 0 = last stage.
  logic [8:0] mq[$];
  // Scoreboard for the 1x1 pipeline: pushed on drive, popped on output.
  logic [1:0] mb[$];

  task automatic model_fill_a(input logic [7:0] v);
    mq.delete();
    repeat (4) mq.push_back({1'b0, v});
  endtask

  function automatic int exp_occ_a();
    int n = 0;
    foreach (mq[i]) n += int'(mq[i][8]);
    return n;
  endfunction

  task automatic cyc_a(input logic en, input logic sclr, input logic sset,
                       input logic [7:0] d, input logic vin);
    bus_a.en   = en;
    bus_a.sclr = sclr;
    bus_a.sset = sset;
    bus_a.d    = d;
    bus_a.vin  = vin;
    @(posedge clk);
    if (sclr) model_fill_a(8'h00);
    else if (sset) model_fill_a(8'hFF);
    else if (en) begin
      mq.push_back({vin, d});
      void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic cyc_b(input logic en, input logic sclr, input logic sset,
                       input logic d, input logic vin);
    bus_b.en   = en;
    bus_b.sclr = sclr;
    bus_b.sset = sset;
    bus_b.d    = d;
    bus_b.vin  = vin;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus_a.en = 1'b1; bus_a.sclr = 1'b0; bus_a.sset = 1'b1; bus_a.d = 8'hC3; bus_a.vin = 1'b1;
    bus_b.en = 1'b1; bus_b.sclr = 1'b0; bus_b.sset = 1'b1; bus_b.d = 1'b1;  bus_b.vin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_a.q !== 8'h00 || bus_a.qn !== 8'hFF || bus_a.vout !== 1'b0 || bus_a.occ !== 3'd0) begin
      errors++;
      $display("FAIL reset_a: q=%h qn=%h vout=%b occ=%0d, want q=00 qn=ff vout=0 occ=0",
               bus_a.q, bus_a.qn, bus_a.vout, bus_a.occ);
    end
    checks++;
    if (bus_b.q !== 1'b0 || bus_b.qn !== 1'b1 || bus_b.vout !== 1'b0 || bus_b.occ !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: q=%b qn=%b vout=%b occ=%0d, want q=0 qn=1 vout=0 occ=0",
               bus_b.q, bus_b.qn, bus_b.vout, bus_b.occ);
    end
    bus_a.en = 1'b0; bus_a.sset = 1'b0; bus_a.vin = 1'b0; bus_a.d = 8'h00;
    bus_b.en = 1'b0; bus_b.sset = 1'b0; bus_b.vin = 1'b0; bus_b.d = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_fill_a(8'h00);
    mb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    logic [7:0] din [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b1, 1'b0, 1'b0, din[i], 1'b1);
      checks++;
      if ({bus_a.vout, bus_a.q} !== mq[0] || bus_a.occ !== 3'(exp_occ_a())) begin
        errors++;
        $display("FAIL fill_edge%0d: vout=%b q=%h occ=%0d, want vout=%b q=%h occ=%0d", i + 1,
                 bus_a.vout, bus_a.q, bus_a.occ, mq[0][8], mq[0][7:0], exp_occ_a());
      end
    end
    checks++;
    if (bus_a.q !== 8'h11 || bus_a.qn !== 8'hEE || bus_a.vout !== 1'b1 || bus_a.occ !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: q=%h qn=%h vout=%b occ=%0d, want q=11 qn=ee vout=1 occ=4",
               bus_a.q, bus_a.qn, bus_a.vout, bus_a.occ);
    end
    cyc_a(1'b1, 1'b0, 1'b0, 8'h55, 1'b1);
    checks++;
    if (bus_a.q !== 8'h22 || bus_a.qn !== 8'hDD || bus_a.occ !== 3'd4) begin
      errors++;
      $display("FAIL fill_edge5: q=%h qn=%h occ=%0d, want q=22 qn=dd occ=4",
               bus_a.q, bus_a.qn, bus_a.occ);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_q [3] = '{8'h00, 8'hA1, 8'hA2};
    logic       exp_v [3] = '{1'b0, 1'b1, 1'b1};
    cyc_a(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc_a(1'b1, 1'b0, 1'b0, 8'hA1, 1'b1);
    cyc_a(1'b1, 1'b0, 1'b0, 8'hA2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc_a(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1);
      checks++;
      if (bus_a.q !== 8'h00 || bus_a.vout !== 1'b0 || bus_a.occ !== 3'd2) begin
        errors++;
        $display("FAIL stall_hold%0d: q=%h vout=%b occ=%0d, want q=00 vout=0 occ=2", i,
                 bus_a.q, bus_a.vout, bus_a.occ);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc_a(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (bus_a.q !== exp_q[i] || bus_a.vout !== exp_v[i] ||
          {bus_a.vout, bus_a.q} !== mq[0] || bus_a.occ !== 3'(exp_occ_a())) begin
        errors++;
        $display("FAIL stall_resume%0d: q=%h vout=%b occ=%0d, want q=%h vout=%b occ=%0d", i + 1,
                 bus_a.q, bus_a.vout, bus_a.occ, exp_q[i], exp_v[i], exp_occ_a());
      end
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] din [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hE5, 8'hE6, 8'hE7};
    logic       vin [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int peak = 0;
    cyc_a(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc_a(1'b1, 1'b0, 1'b0, din[i], vin[i]);
      if (int'(bus_a.occ) > peak) peak = int'(bus_a.occ);
      if (i >= 3) begin
        checks++;
        if (bus_a.q !== din[i-3] || bus_a.vout !== vin[i-3] || bus_a.occ !== 3'(exp_occ_a())) begin
          errors++;
          $display("FAIL bubble_edge%0d: q=%h vout=%b occ=%0d, want q=%h vout=%b occ=%0d", i + 1,
                   bus_a.q, bus_a.vout, bus_a.occ, din[i-3], vin[i-3], exp_occ_a());
        end
      end
    end
    checks++;
    if (peak != 2) begin
      errors++;
      $display("FAIL bubble_peak: occ peak=%0d, want 2", peak);
    end
  endtask

  task automatic test_clear_set();
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 1'b0, 8'h90 + 8'(i), 1'b1);
    cyc_a(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
    checks++;
    if (bus_a.q !== 8'h00 || bus_a.qn !== 8'hFF || bus_a.vout !== 1'b0 || bus_a.occ !== 3'd0) begin
      errors++;
      $display("FAIL clear_wins: q=%h qn=%h vout=%b occ=%0d, want q=00 qn=ff vout=0 occ=0",
               bus_a.q, bus_a.qn, bus_a.vout, bus_a.occ);
    end
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i), 1'b1);
    cyc_a(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    checks++;
    if (bus_a.q !== 8'hFF || bus_a.qn !== 8'h00 || bus_a.vout !== 1'b0 || bus_a.occ !== 3'd0) begin
      errors++;
      $display("FAIL set_only: q=%h qn=%h vout=%b occ=%0d, want q=ff qn=00 vout=0 occ=0",
               bus_a.q, bus_a.qn, bus_a.vout, bus_a.occ);
    end
    // Data from the set pattern must shift out behind new entries.
    cyc_a(1'b1, 1'b0, 1'b0, 8'h12, 1'b1);
    checks++;
    if ({bus_a.vout, bus_a.q} !== mq[0] || bus_a.occ !== 3'd1) begin
      errors++;
      $display("FAIL set_then_shift: vout=%b q=%h occ=%0d, want vout=%b q=%h occ=1",
               bus_a.vout, bus_a.q, bus_a.occ, mq[0][8], mq[0][7:0]);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i), 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus_a.q !== 8'h00 || bus_a.qn !== 8'hFF || bus_a.vout !== 1'b0 || bus_a.occ !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: q=%h qn=%h vout=%b occ=%0d, want q=00 qn=ff vout=0 occ=0",
               bus_a.q, bus_a.qn, bus_a.vout, bus_a.occ);
    end
    model_fill_a(8'h00);
    bus_a.en = 1'b1; bus_a.d = 8'hC7; bus_a.vin = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) cyc_a(1'b1, 1'b0, 1'b0, 8'h5A, 1'b1);
      else cyc_a(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (bus_a.vout !== (k == 4) || (k == 4 && bus_a.q !== 8'h5A) ||
          {bus_a.vout, bus_a.q} !== mq[0]) begin
        errors++;
        $display("FAIL latency_edge%0d: vout=%b q=%h, want vout=%b q=%h", k,
                 bus_a.vout, bus_a.q, mq[0][8], mq[0][7:0]);
      end
    end
  endtask

  task automatic test_width1();
    logic d_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic v_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] exp;
    bus_a.en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mb.push_back({v_tab[i], d_tab[i]});
      cyc_b(1'b1, 1'b0, 1'b0, d_tab[i], v_tab[i]);
      exp = mb.pop_front();
      checks++;
      if (bus_b.q !== exp[0] || bus_b.qn !== ~exp[0] || bus_b.vout !== exp[1] ||
          bus_b.occ !== exp[1]) begin
        errors++;
        $display("FAIL w1_edge%0d: q=%b qn=%b vout=%b occ=%0d, want q=%b vout=%b occ=%0d", i + 1,
                 bus_b.q, bus_b.qn, bus_b.vout, bus_b.occ, exp[0], exp[1], exp[1]);
      end
    end
    cyc_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus_b.q !== 1'b1 || bus_b.vout !== 1'b0) begin
      errors++;
      $display("FAIL w1_hold: q=%b vout=%b, want q=1 vout=0", bus_b.q, bus_b.vout);
    end
    cyc_b(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc_b(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus_b.q !== 1'b1 || bus_b.qn !== 1'b0 || bus_b.vout !== 1'b0 || bus_b.occ !== 1'b0) begin
      errors++;
      $display("FAIL w1_set: q=%b qn=%b vout=%b occ=%0d, want q=1 qn=0 vout=0 occ=0",
               bus_b.q, bus_b.qn, bus_b.vout, bus_b.occ);
    end
    cyc_b(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus_b.q !== 1'b0 || bus_b.qn !== 1'b1 || bus_b.vout !== 1'b0) begin
      errors++;
      $display("FAIL w1_clear: q=%b qn=%b vout=%b, want q=0 qn=1 vout=0",
               bus_b.q, bus_b.qn, bus_b.vout);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus_a.en = 1'b0; bus_a.sclr = 1'b0; bus_a.sset = 1'b0; bus_a.d = 8'h00; bus_a.vin = 1'b0;
    bus_b.en = 1'b0; bus_b.sclr = 1'b0; bus_b.sset = 1'b0; bus_b.d = 1'b0;  bus_b.vin = 1'b0;
    test_reset();
    test_fill();
    test_stall();
    test_bubbles();
    test_clear_set();
    test_async_reset();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
